// File: rtl/act_led_sched.sv
// act_led_sched: time-multiplexed per-drive activity LED stretcher with mode control.
// Optional SGPIO watchdog enabled by ACT_LED_SGPIO_WDT_EN.
module act_led_sched #(
  parameter int NUM_DRV    = 72,
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 5,
  parameter int WDT_TICKS  = 1000
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic [NUM_DRV-1:0] ACT_RAW,
  input  logic               BLINK_CLK,
  input  logic               SGPIO_FRAME,
  input  logic               CFG_WR,
  input  logic [6:0]         CFG_ADDR,
  input  logic [1:0]         CFG_DATA,
  output logic [NUM_DRV-1:0] LED_CATH_L,
  output logic               SCAN_BUSY,
  output logic               WDT_EXPIRED
);
  localparam int IW = NUM_DRV > 1 ? $clog2(NUM_DRV) : 1;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int HW = HOLD_TICKS > 0 ? $clog2(HOLD_TICKS + 1) : 1;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t             state;
  logic [TW-1:0]      tick_cnt;
  logic [IW-1:0]      idx;
  logic [NUM_DRV-1:0] cap;
  logic [NUM_DRV-1:0] clr;
  logic [1:0]         mode [NUM_DRV];
  logic [HW-1:0]      hold [NUM_DRV];
  logic [HW-1:0]      hold_nxt;
  logic               tick, act, led_nxt, cfg_hit;
  assign tick    = tick_cnt == TW'(TICK_DIV - 1);
  assign cfg_hit = CFG_WR && int'(CFG_ADDR) < NUM_DRV;
  always_comb begin
    act      = (cap[idx] | ACT_RAW[idx]) & ~WDT_EXPIRED;
    hold_nxt = act ? HW'(HOLD_TICKS) : hold[idx] - HW'(hold[idx] != '0);
    led_nxt  = mode[idx] == 2'd0 ? hold_nxt == '0 :
               mode[idx] == 2'd1 ? 1'b1 :
               mode[idx] == 2'd2 ? 1'b0 : ~BLINK_CLK;
    clr      = state == SCAN ? NUM_DRV'(1) << idx : '0;
  end
  always_ff @(posedge SYSCLK or negedge RESET_N)
    if (!RESET_N) tick_cnt <= '0;
    else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  // A tick landing mid-pass is simply ignored by the SCAN branches.
  always_ff @(posedge SYSCLK or negedge RESET_N)
    if (!RESET_N) begin
      state     <= IDLE;
      idx       <= '0;
      SCAN_BUSY <= 1'b0;
    end else if (state == SCAN && idx == IW'(NUM_DRV - 1)) begin
      state     <= IDLE;
      idx       <= '0;
      SCAN_BUSY <= 1'b0;
    end else if (state == SCAN) begin
      idx <= idx + 1'b1;
    end else if (tick) begin
      state     <= SCAN;
      SCAN_BUSY <= 1'b1;
    end
  // Fresh activity in the visit cycle keeps the bit set for the next pass.
  always_ff @(posedge SYSCLK or negedge RESET_N)
    if (!RESET_N) cap <= '0;
    else cap <= ACT_RAW | (cap & ~clr);
  always_ff @(posedge SYSCLK or negedge RESET_N)
    if (!RESET_N) begin
      LED_CATH_L <= '1;
      for (int i = 0; i < NUM_DRV; i++) begin
        mode[i] <= 2'd0;
        hold[i] <= '0;
      end
    end else begin
      if (cfg_hit) mode[CFG_ADDR[IW-1:0]] <= CFG_DATA;
      if (state == SCAN) begin
        hold[idx]       <= hold_nxt;
        LED_CATH_L[idx] <= led_nxt;
      end
    end
`ifdef ACT_LED_SGPIO_WDT_EN
  localparam int WW = $clog2(WDT_TICKS + 1);
  logic [WW-1:0] wdt_cnt;
  always_ff @(posedge SYSCLK or negedge RESET_N)
    if (!RESET_N) wdt_cnt <= '0;
    else if (SGPIO_FRAME) wdt_cnt <= '0;
    else if (tick && !WDT_EXPIRED) wdt_cnt <= wdt_cnt + 1'b1;
  assign WDT_EXPIRED = wdt_cnt == WW'(WDT_TICKS);
`else
  logic unused_wdt;
  assign unused_wdt  = SGPIO_FRAME ^ (WDT_TICKS == 0);
  assign WDT_EXPIRED = 1'b0;
`endif
endmodule

// File: tb/tb_act_led_sched.sv
// tb_act_led_sched: randomized scoreboard bench against a pass-level LED model.
module tb_act_led_sched;
  localparam int N = 72, TD = 100, HT = 5, WT = 4;
  logic clk = 0, rst_n = 0, blink = 0, frame = 0, cfg_wr = 0, frames_en = 0;
  logic [N-1:0] act_raw = '0;
  logic [6:0] cfg_addr = '0;
  logic [1:0] cfg_data = '0;
  logic [N-1:0] led;
  logic busy, wdt;
  int tests = 0, fails = 0;
  int p = 0;
  typedef struct {int due; logic [N-1:0] led; logic busy; logic wdt;} exp_t;
  exp_t q[$];
  int mode_m[N];
  int last_act[N];
  bit seen[N];
  logic [N-1:0] led_m;
  int wdt_ticks, vi, pass;

  act_led_sched #(.NUM_DRV(N), .TICK_DIV(TD), .HOLD_TICKS(HT), .WDT_TICKS(WT)) dut (
    .SYSCLK(clk), .RESET_N(rst_n), .ACT_RAW(act_raw), .BLINK_CLK(blink),
    .SGPIO_FRAME(frame), .CFG_WR(cfg_wr), .CFG_ADDR(cfg_addr), .CFG_DATA(cfg_data),
    .LED_CATH_L(led), .SCAN_BUSY(busy), .WDT_EXPIRED(wdt));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) p <= 0;
    else p <= p + 1;

  task automatic check(string name, logic [N-1:0] got, logic [N-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s at interval %0d: got %h expected %h", name, p, got, exp);
    end
  endtask

  function automatic bit wdt_exp_m();
`ifdef ACT_LED_SGPIO_WDT_EN
    return wdt_ticks >= WT;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: tick every TD cycles, drive i seen TD*k+i cycles after reset;
  // an LED in normal mode is lit for HT passes starting at the last active pass.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      led_m = '1;
      wdt_ticks = 0;
      for (int i = 0; i < N; i++) begin
        mode_m[i] = 0;
        last_act[i] = -1000;
        seen[i] = 0;
      end
    end else begin
      vi = p % TD;
      pass = p / TD;
      if (p >= TD && vi < N) begin
        if ((seen[vi] || act_raw[vi]) && !wdt_exp_m()) last_act[vi] = pass;
        case (mode_m[vi])
          0: led_m[vi] = !(pass - last_act[vi] < HT);
          1: led_m[vi] = 1'b1;
          2: led_m[vi] = 1'b0;
          default: led_m[vi] = !blink;
        endcase
        seen[vi] = 0;
      end
      for (int i = 0; i < N; i++) if (act_raw[i]) seen[i] = 1;
      if (cfg_wr && cfg_addr < N) mode_m[cfg_addr] = cfg_data;
      if (frame) wdt_ticks = 0;
      else if (p % TD == TD - 1 && wdt_ticks < WT) wdt_ticks++;
      q.push_back('{p + 1, led_m, (p + 1) >= TD && (p + 1) % TD < N, wdt_exp_m()});
    end
  end

  always @(negedge clk)
    if (rst_n && q.size() > 0 && q[0].due == p) begin
      exp_t e;
      e = q.pop_front();
      check("led", led, e.led);
      check("scan_busy", N'(busy), N'(e.busy));
      check("wdt_expired", N'(wdt), N'(e.wdt));
    end

  initial forever begin
    repeat (300) @(posedge clk);
    #1 blink = ~blink;
  end

  initial forever begin
    @(posedge clk);
    #1 if (frames_en) frame = $urandom_range(0, 39) == 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic cfg(int a, int d);
    cfg_wr = 1;
    cfg_addr = 7'(a);
    cfg_data = 2'(d);
    step();
    cfg_wr = 0;
  endtask

  initial begin
    logic [N-1:0] a;
    int rate;
    repeat (3) step();
    check("reset_led", led, '1);
    check("reset_busy", N'(busy), '0);
    check("reset_wdt", N'(wdt), '0);
    rst_n = 1;
    frames_en = 1;
    run(1000);
    do step(); while (p % TD != 79);
    act_raw[3] = 1;
    step();
    act_raw[3] = 0;
    run(800);
    cfg(10, 2);
    run(300);
    act_raw[10] = 1;
    cfg(10, 1);
    run(300);
    act_raw[10] = 0;
    cfg(71, 3);
    run(1200);
    for (int k = 0; k < 3000; k++) begin
      rate = k < 1500 ? 299 : 39;
      a = '0;
      for (int j = 0; j < N; j++) if ($urandom_range(0, rate) == 0) a[j] = 1;
      act_raw = a;
      cfg_wr = $urandom_range(0, 39) == 0;
      cfg_addr = 7'($urandom_range(0, 80));
      cfg_data = 2'($urandom_range(0, 3));
      step();
    end
    act_raw = '0;
    cfg_wr = 0;
    cfg(72, 2);
    cfg(127, 1);
    cfg(10, 2);
    run(250);
    do step(); while (p % TD != 40);
    check("lit_before_reset", N'(led[10]), '0);
    rst_n = 0;
    #1;
    check("midscan_reset_led", led, '1);
    check("midscan_reset_busy", N'(busy), '0);
    run(2);
    rst_n = 1;
    run(400);
    frames_en = 0;
    frame = 0;
    act_raw[0] = 1;
    run(1200);
    frame = 1;
    step();
    frame = 0;
    run(300);
    act_raw = '0;
    run(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
